// File: rtl/frequency_window_counter.sv
// Measures rising edges, window length and (optionally) high time of a synchronised input
// over start/stop windows. Define FREQUENCY_WINDOW_DUTY_EN to build the high-time counter.
module frequency_window_counter #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start_analyzer,
  input  logic                     stop_analyzer,
  input  logic                     sample_data,
  output logic [COUNTER_WIDTH-1:0] edge_count,
  output logic [COUNTER_WIDTH-1:0] window_cycles,
  output logic [COUNTER_WIDTH-1:0] high_cycles,
  output logic                     overflow,
  output logic                     result_valid,
  output logic                     busy
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   sync_reg;
  logic                     s, prev_reg, rise;
  logic [COUNTER_WIDTH-1:0] window_reg, edge_reg, window_inc, edge_inc;
  logic                     ovf_reg, ovf_inc, high_sat;
  logic                     publish, clear, count;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v,
                                                       input logic inc);
    return (inc && v != CNT_MAX) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sample_data};
      prev_reg <= s;
    end
  end

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~prev_reg;
  assign busy = (state_reg == MEASURE);

  // A stop publishes counts that include the stop cycle; a simultaneous start reopens at once.
  always_comb begin
    state_next = state_reg;
    publish    = 1'b0;
    clear      = 1'b0;
    count      = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_analyzer) begin
            clear      = 1'b1;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (stop_analyzer) begin
            publish    = 1'b1;
            count      = 1'b1;
            clear      = start_analyzer;
            state_next = start_analyzer ? MEASURE : IDLE;
          end else if (start_analyzer) begin
            clear = 1'b1;
          end else begin
            count = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign window_inc = sat_inc(window_reg, 1'b1);
  assign edge_inc   = sat_inc(edge_reg, rise);
  assign ovf_inc    = ovf_reg | (window_reg == CNT_MAX) | (rise && edge_reg == CNT_MAX) | high_sat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      window_reg    <= '0;
      edge_reg      <= '0;
      ovf_reg       <= 1'b0;
      window_cycles <= '0;
      edge_count    <= '0;
      overflow      <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      result_valid <= publish;
      if (publish) begin
        window_cycles <= window_inc;
        edge_count    <= edge_inc;
        overflow      <= ovf_inc;
      end
      if (clear) begin
        window_reg <= '0;
        edge_reg   <= '0;
        ovf_reg    <= 1'b0;
      end else if (count) begin
        window_reg <= window_inc;
        edge_reg   <= edge_inc;
        ovf_reg    <= ovf_inc;
      end
    end
  end

`ifdef FREQUENCY_WINDOW_DUTY_EN
  logic [COUNTER_WIDTH-1:0] high_reg, high_inc;

  assign high_inc = sat_inc(high_reg, s);
  assign high_sat = s && (high_reg == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      high_reg    <= '0;
      high_cycles <= '0;
    end else begin
      if (publish) high_cycles <= high_inc;
      if (clear) high_reg <= '0;
      else if (count) high_reg <= high_inc;
    end
  end
`else
  assign high_sat    = 1'b0;
  assign high_cycles = '0;
`endif

endmodule

// File: tb/tb_frequency_window_counter.sv
// Self-checking bench for frequency_window_counter (8-bit counters): vector table, directed
// windows and random stimulus against a cycle-history reference model.
module tb_frequency_window_counter;
  localparam int CW   = 8;
  localparam int SS   = 2;
  localparam int MAXV = (1 << CW) - 1;
`ifdef FREQUENCY_WINDOW_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1, enable = 1'b0, start_analyzer = 1'b0, stop_analyzer = 1'b0;
  logic          sample_data = 1'b0;
  logic [CW-1:0] edge_count, window_cycles, high_cycles;
  logic          overflow, result_valid, busy;

  frequency_window_counter #(.COUNTER_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start_analyzer(start_analyzer),
    .stop_analyzer(stop_analyzer), .sample_data(sample_data), .edge_count(edge_count),
    .window_cycles(window_cycles), .high_cycles(high_cycles), .overflow(overflow),
    .result_valid(result_valid), .busy(busy));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int cyc = 0, rv_cnt = 0, wave_mode = 0;

  // Reference model: sample history as seen at each clock edge plus unbounded window tallies.
  bit hist[$];
  bit m_open;
  int m_win, m_edge, m_high;
  int e_win, e_edge, e_high;
  bit e_ovf, e_rv;

  function automatic int sat(int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(bit rst, bit en, bit st, bit sp, bit smp);
    bit s, p;
    if (rst) begin
      hist.delete();
      repeat (SS + 1) hist.push_back(1'b0);
      m_open = 0; e_win = 0; e_edge = 0; e_high = 0; e_ovf = 0; e_rv = 0;
      m_win = 0; m_edge = 0; m_high = 0;
      return;
    end
    hist.push_back(smp);
    if (hist.size() > 16) void'(hist.pop_front());
    s = hist[hist.size() - 1 - SS];
    p = hist[hist.size() - 2 - SS];
    e_rv = 0;
    if (!en) begin
      m_open = 0;
    end else if (!m_open) begin
      if (st) begin
        m_open = 1; m_win = 0; m_edge = 0; m_high = 0;
      end
    end else if (st && !sp) begin
      m_win = 0; m_edge = 0; m_high = 0;
    end else begin
      m_win++;
      if (s && !p) m_edge++;
      if (s) m_high++;
      if (sp) begin
        e_win  = sat(m_win);
        e_edge = sat(m_edge);
        e_high = DUTY ? sat(m_high) : 0;
        e_ovf  = (m_win > MAXV) || (m_edge > MAXV) || (DUTY && m_high > MAXV);
        e_rv   = 1;
        if (st) begin
          m_win = 0; m_edge = 0; m_high = 0;
        end else begin
          m_open = 0;
        end
      end
    end
  endtask

  task automatic apply(bit rst, bit en, bit st, bit sp, bit smp);
    reset = rst; enable = en; start_analyzer = st; stop_analyzer = sp; sample_data = smp;
    @(posedge clock);
    #1;
    cyc++;
    model_step(rst, en, st, sp, smp);
    if (result_valid) rv_cnt++;
    chk("busy", int'(busy), int'(m_open));
    chk("result_valid", int'(result_valid), int'(e_rv));
    chk("window_cycles", int'(window_cycles), e_win);
    chk("edge_count", int'(edge_count), e_edge);
    chk("high_cycles", int'(high_cycles), e_high);
    chk("overflow", int'(overflow), int'(e_ovf));
  endtask

  function automatic bit wave();
    case (wave_mode)
      1:       return 1'b1;
      2:       return (cyc % 10) < 5;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick(bit st, bit sp);
    apply(1'b0, 1'b1, st, sp, wave());
  endtask

  typedef struct {
    bit rst, en, st, sp;
    bit busy, rv;
    int win;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int rv0, busy_low;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_busy", int'(busy), 0);
    chk("reset_window", int'(window_cycles), 0);
    chk("reset_edges", int'(edge_count), 0);
    chk("reset_high", int'(high_cycles), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_valid", int'(result_valid), 0);

    // Vector table: rst en st sp -> busy rv window (sample held low)
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 1, 3};
    tbl[6]  = '{0, 1, 1, 1, 1, 0, 3};
    tbl[7]  = '{0, 1, 1, 1, 1, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 1, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 0, 1, 2};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 2};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 2};
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].st, tbl[i].sp, 1'b0);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_valid", i), int'(result_valid), int'(tbl[i].rv));
      chk($sformatf("tbl%0d_window", i), int'(window_cycles), tbl[i].win);
    end

    // Square wave, 100-cycle window
    wave_mode = 2;
    repeat (20) tick(0, 0);
    rv0 = rv_cnt;
    tick(1, 0);
    repeat (99) tick(0, 0);
    tick(0, 1);
    chk("sq_valid", int'(result_valid), 1);
    chk("sq_valid_count", rv_cnt - rv0, 1);
    chk("sq_window", int'(window_cycles), 100);
    chk("sq_edges", int'(edge_count), 10);
    chk("sq_high", int'(high_cycles), DUTY ? 50 : 0);
    tick(0, 0);
    chk("sq_valid_pulse", int'(result_valid), 0);

    // Saturation: constant high over 300 clocks
    wave_mode = 1;
    repeat (10) tick(0, 0);
    tick(1, 0);
    repeat (299) tick(0, 0);
    tick(0, 1);
    chk("sat_window", int'(window_cycles), 255);
    chk("sat_high", int'(high_cycles), DUTY ? 255 : 0);
    chk("sat_edges", int'(edge_count), 0);
    chk("sat_overflow", int'(overflow), 1);

    // Back-to-back windows of 50 and 30
    wave_mode = 2;
    repeat (10) tick(0, 0);
    busy_low = 0;
    tick(1, 0);
    busy_low += int'(!busy);
    for (int i = 1; i < 50; i++) begin tick(0, 0); busy_low += int'(!busy); end
    tick(1, 1);
    busy_low += int'(!busy);
    chk("b2b_valid1", int'(result_valid), 1);
    chk("b2b_window1", int'(window_cycles), 50);
    chk("b2b_edges1", int'(edge_count), 5);
    for (int i = 51; i < 80; i++) begin tick(0, 0); busy_low += int'(!busy); end
    chk("b2b_busy_low", busy_low, 0);
    tick(0, 1);
    chk("b2b_valid2", int'(result_valid), 1);
    chk("b2b_window2", int'(window_cycles), 30);
    chk("b2b_edges2", int'(edge_count), 3);
    chk("b2b_busy_end", int'(busy), 0);

    // Restart mid-window, then a stray stop in IDLE
    wave_mode = 0;
    rv0 = rv_cnt;
    tick(1, 0);
    repeat (39) tick(0, 0);
    tick(1, 0);
    repeat (19) tick(0, 0);
    tick(0, 1);
    chk("restart_window", int'(window_cycles), 20);
    chk("restart_valid_count", rv_cnt - rv0, 1);
    tick(0, 1);
    chk("stray_stop_valid", int'(result_valid), 0);

    // Abort by enable=0, then reset mid-window
    rv0 = rv_cnt;
    tick(1, 0);
    repeat (29) tick(0, 0);
    apply(0, 0, 0, 0, 1'b0);
    apply(0, 0, 0, 1, 1'b0);
    apply(0, 1, 0, 1, 1'b0);
    chk("abort_valid_count", rv_cnt - rv0, 0);
    chk("abort_window_held", int'(window_cycles), 20);
    chk("abort_busy", int'(busy), 0);
    tick(1, 0);
    repeat (10) tick(0, 0);
    apply(1, 1, 0, 0, 1'b0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_window", int'(window_cycles), 0);

    // Random: short windows, then long windows that can saturate
    for (int i = 0; i < 2000; i++)
      apply($urandom_range(199) == 0, $urandom_range(31) != 0, $urandom_range(15) == 0,
            $urandom_range(15) == 0, $urandom_range(3) == 0 ? ~sample_data : sample_data);
    for (int i = 0; i < 2000; i++)
      apply(1'b0, $urandom_range(999) != 0, $urandom_range(199) == 0,
            $urandom_range(299) == 0, $urandom_range(2) == 0 ? ~sample_data : sample_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
